uart_multi_report: RTL and testbench



---
 rtl/uart_multi_report_if.sv | 19 +
 rtl/uart_multi_report.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_multi_report.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_multi_report_if.sv
// Byte-stream handshake between the report formatter and a uart_tx serialiser.
// The master presents tx_data with tx_valid; the slave accepts with tx_ready.
interface uart_multi_report_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_multi_report.sv
// uart_multi_report: captures an NCH-channel snapshot plus a weather class on
// each rising edge of data_ready and streams one ASCII status line:
//   C<c>:<hhh>.<d> (per channel) W:<class text> \r\n
// A single pending slot coalesces snapshots that arrive while a line is in
// flight; overwrites of a still-pending snapshot are counted in drop_cnt.
// Optional feature macro: UART_REPORT_CHECKSUM_EN appends "*hh" (XOR of all
// bytes before the '*', uppercase hex) ahead of the \r\n terminator.
module uart_multi_report #(
    parameter int NCH   = 2,
    parameter int CLS_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_ready,
    input  logic [NCH*8-1:0]    chan_int,
    input  logic [NCH*8-1:0]    chan_dec,
    input  logic [CLS_W-1:0]    weather_class,
    uart_multi_report_if.master tx,
    output logic                busy,
    output logic                line_done,
    output logic [7:0]          drop_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam int IDX_W = 7;
    localparam logic [IDX_W-1:0] CH_BYTES = IDX_W'(9 * NCH);
`ifdef UART_REPORT_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CS_BYTES = 7'd3;
`else
    localparam logic [IDX_W-1:0] CS_BYTES = 7'd0;
`endif

    // Length of the class text, without padding.
    function automatic logic [3:0] cls_len(input logic [CLS_W-1:0] c);
        case (32'(c))
            32'd0:   cls_len = 4'd5;
            32'd1:   cls_len = 4'd8;
            32'd2:   cls_len = 4'd7;
            32'd3:   cls_len = 4'd8;
            32'd4:   cls_len = 4'd8;
            default: cls_len = 4'd7;
        endcase
    endfunction

    // Class text left-aligned in 8 bytes; first character in the top byte.
    function automatic logic [63:0] cls_text(input logic [CLS_W-1:0] c);
        case (32'(c))
            32'd0:   cls_text = {"CLEAR", 24'h000000};
            32'd1:   cls_text = "RAIN_OVC";
            32'd2:   cls_text = {"RAIN_PC", 8'h00};
            32'd3:   cls_text = "PART_CLD";
            32'd4:   cls_text = "OVERCAST";
            default: cls_text = {"UNKNOWN", 8'h00};
        endcase
    endfunction

    // Character k (0-based) of the class text.
    function automatic logic [7:0] cls_char(input logic [CLS_W-1:0] c,
                                            input logic [2:0] k);
        logic [63:0] t;
        t = cls_text(c);
        cls_char = t[8*(3'd7 - k) +: 8];
    endfunction

    // ASCII decimal digit of an unsigned byte: sel 0 hundreds, 1 tens, 2 ones.
    function automatic logic [7:0] dec_digit(input logic [7:0] v,
                                             input logic [1:0] sel);
        logic [7:0] d;
        case (sel)
            2'd0:    d = v / 8'd100;
            2'd1:    d = (v / 8'd10) % 8'd10;
            default: d = v % 8'd10;
        endcase
        dec_digit = 8'h30 + d;
    endfunction

    // Uppercase ASCII hex nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    logic [0:0]            state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [3:0]            ch_q;
    logic [3:0]            pos_q;
    logic                  dr_q;
    logic [NCH*8-1:0]      act_int;
    logic [NCH*8-1:0]      act_dec;
    logic [CLS_W-1:0]      act_cls;
    logic [NCH*8-1:0]      pend_int;
    logic [NCH*8-1:0]      pend_dec;
    logic [CLS_W-1:0]      pend_cls;
    logic                  pend_v;

    logic                  edge_det;
    logic                  accept;
    logic                  last_byte;
    logic                  line_start;
    logic [IDX_W-1:0]      t_idx;
    logic [IDX_W-1:0]      clen7;
    logic [IDX_W-1:0]      last_idx;
    logic [7:0]            cur_int;
    logic [7:0]            cur_dec;

`ifdef UART_REPORT_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    assign edge_det   = data_ready & ~dr_q;
    assign tx.tx_valid = (state_q == S_SEND);
    assign busy       = (state_q == S_SEND);
    assign accept     = tx.tx_valid & tx.tx_ready;

    assign clen7      = {3'b000, cls_len(act_cls)};
    assign t_idx      = idx_q - CH_BYTES;
    assign last_idx   = CH_BYTES + clen7 + 7'd3 + CS_BYTES;
    assign last_byte  = (idx_q == last_idx);

    // A line begins either from idle or seamlessly after the final byte.
    assign line_start = ((state_q == S_IDLE) & edge_det) |
                        ((state_q == S_SEND) & accept & last_byte & (edge_det | pend_v));

    // Select the active channel's integer and fraction bytes.
    always_comb begin
        cur_int = 8'h00;
        cur_dec = 8'h00;
        for (int c = 0; c < NCH; c++) begin
            if (ch_q == 4'(c)) begin
                cur_int = act_int[c*8 +: 8];
                cur_dec = act_dec[c*8 +: 8];
            end
        end
    end

    // Compose the byte at the current line position.
    always_comb begin
        tx.tx_data = 8'h00;
        if (state_q == S_SEND) begin
            if (idx_q < CH_BYTES) begin
                case (pos_q)
                    4'd0:    tx.tx_data = "C";
                    4'd1:    tx.tx_data = 8'h30 + {4'h0, ch_q};
                    4'd2:    tx.tx_data = ":";
                    4'd3:    tx.tx_data = dec_digit(cur_int, 2'd0);
                    4'd4:    tx.tx_data = dec_digit(cur_int, 2'd1);
                    4'd5:    tx.tx_data = dec_digit(cur_int, 2'd2);
                    4'd6:    tx.tx_data = ".";
                    4'd7:    tx.tx_data = dec_digit(cur_dec, 2'd2);
                    4'd8:    tx.tx_data = " ";
                    default: tx.tx_data = 8'h00;
                endcase
            end else if (t_idx == 7'd0) begin
                tx.tx_data = "W";
            end else if (t_idx == 7'd1) begin
                tx.tx_data = ":";
            end else if (t_idx < clen7 + 7'd2) begin
                tx.tx_data = cls_char(act_cls, 3'(t_idx - 7'd2));
`ifdef UART_REPORT_CHECKSUM_EN
            end else if (t_idx == clen7 + 7'd2) begin
                tx.tx_data = "*";
            end else if (t_idx == clen7 + 7'd3) begin
                tx.tx_data = hex_char(csum_q[7:4]);
            end else if (t_idx == clen7 + 7'd4) begin
                tx.tx_data = hex_char(csum_q[3:0]);
`endif
            end else if (t_idx == clen7 + 7'd2 + CS_BYTES) begin
                tx.tx_data = 8'h0D;
            end else begin
                tx.tx_data = 8'h0A;
            end
        end
    end

    // Line sequencer, snapshot capture, pending slot and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ch_q      <= '0;
            pos_q     <= '0;
            dr_q      <= 1'b0;
            act_int   <= '0;
            act_dec   <= '0;
            act_cls   <= '0;
            pend_int  <= '0;
            pend_dec  <= '0;
            pend_cls  <= '0;
            pend_v    <= 1'b0;
            line_done <= 1'b0;
            drop_cnt  <= 8'h00;
        end else begin
            dr_q      <= data_ready;
            line_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (edge_det) begin
                        act_int <= chan_int;
                        act_dec <= chan_dec;
                        act_cls <= weather_class;
                        idx_q   <= '0;
                        ch_q    <= '0;
                        pos_q   <= '0;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (accept && last_byte) begin
                        line_done <= 1'b1;
                        idx_q     <= '0;
                        ch_q      <= '0;
                        pos_q     <= '0;
                        if (edge_det) begin
                            // Fresh data on the closing byte supersedes any pending snapshot.
                            act_int <= chan_int;
                            act_dec <= chan_dec;
                            act_cls <= weather_class;
                            pend_v  <= 1'b0;
                        end else if (pend_v) begin
                            act_int <= pend_int;
                            act_dec <= pend_dec;
                            act_cls <= pend_cls;
                            pend_v  <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        if (accept) begin
                            idx_q <= idx_q + 7'd1;
                            if (idx_q < CH_BYTES) begin
                                if (pos_q == 4'd8) begin
                                    pos_q <= 4'd0;
                                    if (ch_q != 4'(NCH - 1)) begin
                                        ch_q <= ch_q + 4'd1;
                                    end
                                end else begin
                                    pos_q <= pos_q + 4'd1;
                                end
                            end
                        end
                        if (edge_det) begin
                            pend_int <= chan_int;
                            pend_dec <= chan_dec;
                            pend_cls <= weather_class;
                            pend_v   <= 1'b1;
                            if (pend_v && (drop_cnt != 8'hFF)) begin
                                drop_cnt <= drop_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef UART_REPORT_CHECKSUM_EN
    // Running XOR of every accepted byte ahead of the '*' marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else if (line_start) begin
            csum_q <= 8'h00;
        end else if (accept && (idx_q < CH_BYTES + clen7 + 7'd2)) begin
            csum_q <= csum_q ^ tx.tx_data;
        end
    end
`endif

endmodule

// File: tb/tb_uart_multi_report.sv
// Scoreboard bench for uart_multi_report (NCH=2, CLS_W=3). Stimulus pushes the
// expected line bytes into a queue; a negedge monitor pops and compares each
// byte the DUT hands over, and checks that stalled bytes stay put.
module tb_uart_multi_report;
    localparam int NCH   = 2;
    localparam int CLS_W = 3;
`ifdef UART_REPORT_CHECKSUM_EN
    localparam int CS = 3;
`else
    localparam int CS = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             data_ready;
    logic [NCH*8-1:0] chan_int;
    logic [NCH*8-1:0] chan_dec;
    logic [CLS_W-1:0] weather_class;
    logic             busy;
    logic             line_done;
    logic [7:0]       drop_cnt;

    uart_multi_report_if ifc ();

    uart_multi_report #(.NCH(NCH), .CLS_W(CLS_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_ready    (data_ready),
        .chan_int      (chan_int),
        .chan_dec      (chan_dec),
        .weather_class (weather_class),
        .tx            (ifc),
        .busy          (busy),
        .line_done     (line_done),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         acc_cnt  = 0;
    int         ld_cnt   = 0;
    bit         rnd_en   = 1'b0;
    bit         stall_pend = 1'b0;
    logic [7:0] stall_byte = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected line text, with the checksum suffix when that feature is built in.
    function automatic string full_line(input string s);
`ifdef UART_REPORT_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < s.len() - 2; i++) x = x ^ s[i];
        return {s.substr(0, s.len() - 3), "*", $sformatf("%02X", x), "\r\n"};
`else
        return s;
`endif
    endfunction

    task automatic push_line(input string s);
        string t;
        t = full_line(s);
        for (int i = 0; i < t.len(); i++) exp_q.push_back(t[i]);
    endtask

    task automatic push_prefix(input string s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_snap(input logic [7:0] i0, input logic [7:0] i1,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [CLS_W-1:0] c);
        chan_int      = {i1, i0};
        chan_dec      = {d1, d0};
        weather_class = c;
    endtask

    task automatic pulse();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    // Serialiser model: always ready, or random back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        ifc.tx_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compares accepted bytes, holds stalled bytes to account.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("stall_valid_held", 32'(ifc.tx_valid), 32'd1);
                chk("stall_data_stable", 32'(ifc.tx_data), 32'(stall_byte));
            end
            if (ifc.tx_valid && ifc.tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("byte_without_expectation", 32'(ifc.tx_data), 32'h100);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk($sformatf("byte%0d", acc_cnt), 32'(ifc.tx_data), 32'(e));
                end
                acc_cnt++;
            end
            stall_pend = ifc.tx_valid && !ifc.tx_ready;
            stall_byte = ifc.tx_data;
            if (line_done) ld_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int    base;
        int    ld0;
        logic [7:0] drop0;
        string s5;

        rst        = 1'b1;
        data_ready = 1'b0;
        set_snap(8'd0, 8'd0, 8'd0, 8'd0, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(ifc.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(ifc.tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_line_done", 32'(line_done), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Basic line, always-ready serialiser, first-byte latency.
        set_snap(8'd25, 8'd60, 8'd3, 8'd7, 3'd0);
        push_line("C0:025.3 C1:060.7 W:CLEAR\r\n");
        base = acc_cnt;
        ld0  = ld_cnt;
        data_ready = 1'b1;
        @(negedge clk);
        chk("pre_capture_valid", 32'(ifc.tx_valid), 32'd0);
        tick();
        data_ready = 1'b0;
        @(negedge clk);
        chk("latency_valid", 32'(ifc.tx_valid), 32'd1);
        chk("latency_busy", 32'(busy), 32'd1);
        wait_idle(200, "s1_timeout");
        chk("s1_bytes", 32'(acc_cnt - base), 32'(27 + CS));
        chk("s1_line_done", 32'(ld_cnt - ld0), 32'd1);
        chk("s1_busy_after", 32'(busy), 32'd0);

        // Same line under random back-pressure.
        tick();
        push_line("C0:025.3 C1:060.7 W:CLEAR\r\n");
        base = acc_cnt;
        ld0  = ld_cnt;
        rnd_en = 1'b1;
        pulse();
        wait_idle(1000, "s2_timeout");
        rnd_en = 1'b0;
        chk("s2_bytes", 32'(acc_cnt - base), 32'(27 + CS));
        chk("s2_line_done", 32'(ld_cnt - ld0), 32'd1);
        tick();
        tick();

        // Three mid-line edges: only the last survives, two drops counted.
        set_snap(8'd9, 8'd0, 8'd255, 8'd10, 3'd2);
        push_line("C0:009.5 C1:000.0 W:RAIN_PC\r\n");
        push_line("C0:123.5 C1:200.9 W:PART_CLD\r\n");
        base = acc_cnt;
        ld0  = ld_cnt;
        pulse();
        wait_acc(base + 5, 100, "s3_wait5");
        tick();
        set_snap(8'd11, 8'd22, 8'd1, 8'd2, 3'd1);
        pulse();
        wait_acc(base + 10, 100, "s3_wait10");
        tick();
        set_snap(8'd33, 8'd44, 8'd5, 8'd6, 3'd4);
        pulse();
        wait_acc(base + 15, 100, "s3_wait15");
        tick();
        set_snap(8'd123, 8'd200, 8'd45, 8'd99, 3'd3);
        pulse();
        wait_idle(300, "s3_timeout");
        repeat (10) tick();
        chk("s3_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("s3_line_done", 32'(ld_cnt - ld0), 32'd2);
        chk("s3_bytes", 32'(acc_cnt - base), 32'(59 + 2 * CS));
        chk("s3_busy_after", 32'(busy), 32'd0);

        // Edge coincident with acceptance of the closing '\n'.
        set_snap(8'd2, 8'd1, 8'd4, 8'd3, 3'd4);
        push_line("C0:002.4 C1:001.3 W:OVERCAST\r\n");
        push_line("C0:100.6 C1:099.8 W:CLEAR\r\n");
        base  = acc_cnt;
        ld0   = ld_cnt;
        drop0 = drop_cnt;
        pulse();
        repeat (30 + CS - 1) tick();
        set_snap(8'd100, 8'd99, 8'd6, 8'd8, 3'd0);
        data_ready = 1'b1;
        @(negedge clk);
        chk("s4_newline_presented", 32'(ifc.tx_data), 32'h0A);
        tick();
        data_ready = 1'b0;
        @(negedge clk);
        chk("s4_line_done", 32'(line_done), 32'd1);
        chk("s4_no_gap_valid", 32'(ifc.tx_valid), 32'd1);
        chk("s4_busy_held", 32'(busy), 32'd1);
        chk("s4_drop_unchanged", 32'(drop_cnt), 32'(drop0));
        wait_idle(300, "s4_timeout");
        chk("s4_bytes", 32'(acc_cnt - base), 32'(57 + 2 * CS));
        chk("s4_line_done_total", 32'(ld_cnt - ld0), 32'd2);

        // Unknown class and extreme values; reset abandons the line mid-way.
        tick();
        s5 = "C0:255.9 C1:000.9 W:UNKNOWN\r\n";
        set_snap(8'd255, 8'd0, 8'd19, 8'd19, 3'd7);
        push_prefix(s5, 12);
        base = acc_cnt;
        pulse();
        repeat (12) tick();
        rst = 1'b1;
        #1;
        chk("s5_rst_valid", 32'(ifc.tx_valid), 32'd0);
        chk("s5_rst_data", 32'(ifc.tx_data), 32'd0);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        chk("s5_rst_drop", 32'(drop_cnt), 32'd0);
        chk("s5_bytes_before_rst", 32'(acc_cnt - base), 32'd12);
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("s5_idle_after_rst", 32'(busy), 32'd0);
        chk("s5_queue_drained", 32'(exp_q.size()), 32'd0);

        // A fresh edge after reset prints the complete line.
        push_line(s5);
        base = acc_cnt;
        ld0  = ld_cnt;
        pulse();
        wait_idle(200, "s5_timeout");
        chk("s5_bytes", 32'(acc_cnt - base), 32'(29 + CS));
        chk("s5_line_done", 32'(ld_cnt - ld0), 32'd1);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
